// File: rtl/multdiv_issue_pkg.sv
// Shared types and defaults for the multdiv requester: FSM states, op encodings, sizing.
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      WB
   } state_e;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int unsigned TIMEOUT_DEF = 48;
   localparam int unsigned RD_W_DEF    = 5;

endpackage

// File: rtl/multdiv_issue_if.sv
// Bundle of issue, multdiv and writeback signals; master is the requester, slave the environment.
interface multdiv_issue_if
   import multdiv_pkg::*;
#(
   parameter int unsigned RD_W = RD_W_DEF
);

   logic            issue_valid;
   logic            issue_is_div;
   logic [31:0]     issue_opA;
   logic [31:0]     issue_opB;
   logic [RD_W-1:0] issue_rd;
   logic            issue_ready;
   logic            flush;
   logic            stall;
   logic [31:0]     md_operandA;
   logic [31:0]     md_operandB;
   logic            md_ctrl_MULT;
   logic            md_ctrl_DIV;
   logic [31:0]     md_result;
   logic            md_exception;
   logic            md_resultRDY;
   logic            wb_valid;
   logic [RD_W-1:0] wb_rd;
   logic [31:0]     wb_data;
   logic            wb_exception;

   modport master (
      input  issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
             md_result, md_exception, md_resultRDY,
      output issue_ready, stall, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
             wb_valid, wb_rd, wb_data, wb_exception
   );

   modport slave (
      output issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
             md_result, md_exception, md_resultRDY,
      input  issue_ready, stall, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
             wb_valid, wb_rd, wb_data, wb_exception
   );

endinterface

// File: rtl/md_timeout_ctr.sv
// WAIT-phase cycle counter: clear, saturating increment, and flags for the first and last cycle.
module md_timeout_ctr #(
   parameter int unsigned TIMEOUT = 48
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic zero_o,
   output logic expired_o
);

   localparam int unsigned     CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o    = (cnt_q == '0);
   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/multdiv_issue.sv
// Execute-stage requester for multdiv: latch op, pulse start, wait for ready or timeout, write back.
module multdiv_issue
   import multdiv_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned RD_W    = RD_W_DEF
) (
   input logic             clock,
   input logic             reset_n,
   multdiv_issue_if.master bus
);

   state_e          st_q;
   logic            ready_q;
   logic            mult_q, div_q;
   logic [31:0]     opa_q, opb_q;
   logic [RD_W-1:0] rd_q;
   logic            wb_valid_q;
   logic [RD_W-1:0] wb_rd_q;
   logic [31:0]     wb_data_q;
   logic            wb_exc_q;
   logic            cnt_zero, cnt_expired;

   md_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk_i    (clock),
      .rst_ni   (reset_n),
      .clr_i    (st_q == START),
      .en_i     (st_q == WAIT),
      .zero_o   (cnt_zero),
      .expired_o(cnt_expired)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         st_q       <= IDLE;
         ready_q    <= 1'b1;
         mult_q     <= 1'b0;
         div_q      <= 1'b0;
         opa_q      <= '0;
         opb_q      <= '0;
         rd_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         wb_exc_q   <= 1'b0;
      end else begin
         mult_q     <= 1'b0;
         div_q      <= 1'b0;
         wb_valid_q <= 1'b0;
         // Flush outranks issue and ready; a pulse already on the wire in START still reaches multdiv.
         if (bus.flush) begin
            st_q    <= IDLE;
            ready_q <= 1'b1;
         end else begin
            case (st_q)
               IDLE: begin
                  if (bus.issue_valid) begin
                     opa_q   <= bus.issue_opA;
                     opb_q   <= bus.issue_opB;
                     rd_q    <= bus.issue_rd;
                     mult_q  <= (bus.issue_is_div == OP_MULT);
                     div_q   <= (bus.issue_is_div == OP_DIV);
                     ready_q <= 1'b0;
                     st_q    <= START;
                  end
               end
               START: st_q <= WAIT;
               WAIT: begin
                  // First WAIT cycle masks a ready left over from the previous op.
                  if (bus.md_resultRDY && !cnt_zero) begin
                     wb_data_q  <= bus.md_result;
                     wb_exc_q   <= bus.md_exception;
                     wb_rd_q    <= rd_q;
                     wb_valid_q <= 1'b1;
                     st_q       <= WB;
                  end else if (cnt_expired) begin
                     wb_data_q  <= '0;
                     wb_exc_q   <= 1'b1;
                     wb_rd_q    <= rd_q;
                     wb_valid_q <= 1'b1;
                     st_q       <= WB;
                  end
               end
               WB: begin
                  ready_q <= 1'b1;
                  st_q    <= IDLE;
               end
               default: begin
                  ready_q <= 1'b1;
                  st_q    <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.stall = (st_q == START) || (st_q == WAIT) ||
                      ((st_q == IDLE) && bus.issue_valid && !bus.flush);

   assign bus.issue_ready  = ready_q;
   assign bus.md_operandA  = opa_q;
   assign bus.md_operandB  = opb_q;
   assign bus.md_ctrl_MULT = mult_q;
   assign bus.md_ctrl_DIV  = div_q;
   assign bus.wb_valid     = wb_valid_q;
   assign bus.wb_rd        = wb_rd_q;
   assign bus.wb_data      = wb_data_q;
   assign bus.wb_exception = wb_exc_q;

endmodule
